// File: rtl/i2c_adc_scan_pkg.sv
// Shared definitions for the I2C ADC sequencer: engine command bits and FSM state encoding.
package i2c_adc_scan_pkg;

    localparam logic [4:0] CMD_START = 5'b00001;
    localparam logic [4:0] CMD_WRITE = 5'b00010;
    localparam logic [4:0] CMD_READ  = 5'b00100;
    localparam logic [4:0] CMD_STOP  = 5'b01000;
    localparam logic [4:0] CMD_ACK   = 5'b10000;

    typedef enum logic [3:0] {
        IDLE, S_DEV, S_REG, S_RDEV, S_RB0, S_RB1, S_NEXT,
        W_DEV, W_REG, W_DAT, ABORT
    } state_t;

endpackage

// File: rtl/adc_sample_align.sv
// Combines the two read bytes into a 16-bit raw word and extracts the sample field.
module adc_sample_align #(
    parameter int DATA_W    = 12,
    parameter int LSB_SHIFT = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [7:0]        b0,
    input  logic [7:0]        b1,
    output logic [DATA_W-1:0] sample
);

    logic [15:0] raw;
    logic        unused_raw;

    assign raw        = MSB_FIRST ? {b0, b1} : {b1, b0};
    assign sample     = raw[LSB_SHIFT +: DATA_W];
    // Bits outside the sample field are intentionally dropped.
    assign unused_raw = ^raw;

endmodule

// File: rtl/i2c_adc_scan.sv
// Multi-channel I2C ADC sequencer: periodic channel scans and register writes via the byte-level engine.
module i2c_adc_scan
    import i2c_adc_scan_pkg::*;
#(
    parameter int         NUM_CH      = 4,
    parameter int         DATA_W      = 12,
    parameter int         LSB_SHIFT   = 4,
    parameter bit         MSB_FIRST   = 1'b0,
    parameter logic [6:0] DEV_ID      = 7'h48,
    parameter logic [7:0] CH_REG_BASE = 8'h00,
    parameter int         PERIOD_CYC  = 100000,
    parameter int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     scan_en,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic                     cfg_wr_req,
    input  logic [7:0]               cfg_reg_addr,
    input  logic [7:0]               cfg_wr_data,
    output logic                     ready,
    output logic [4:0]               i2c_cmd,
    output logic                     i2c_cmd_vld,
    output logic [7:0]               i2c_wr_data,
    input  logic [7:0]               i2c_rd_data,
    input  logic                     i2c_done,
    input  logic                     i2c_ack_err,
    output logic [DATA_W-1:0]        smp_data,
    output logic [CH_W-1:0]          smp_ch,
    output logic                     smp_vld,
    output logic [NUM_CH*DATA_W-1:0] smp_bank,
    output logic                     scan_done,
    output logic                     err
);

    localparam int CNT_W = $clog2(PERIOD_CYC);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                scan_pend;
    logic [NUM_CH-1:0]   mask_q;
    logic [CH_W-1:0]     ch;
    logic                in_scan;
    logic                smp_ok;
    logic [7:0]          b0, b1;
    logic [7:0]          wr_addr, wr_dat;
    logic [DATA_W-1:0]   sample;
    logic [CH_W-1:0]     first_ch, next_ch;
    logic                first_ok, next_ok;

    adc_sample_align #(
        .DATA_W    (DATA_W),
        .LSB_SHIFT (LSB_SHIFT),
        .MSB_FIRST (MSB_FIRST)
    ) u_align (
        .b0     (b0),
        .b1     (b1),
        .sample (sample)
    );

    assign ready = (state == IDLE) && !scan_pend;

    // Downward loops leave the lowest qualifying index as the winner.
    always_comb begin
        first_ch = '0;
        first_ok = 1'b0;
        next_ch  = '0;
        next_ok  = 1'b0;
        for (int k = NUM_CH-1; k >= 0; k--) begin
            if (ch_mask[k]) begin
                first_ch = CH_W'(k);
                first_ok = 1'b1;
            end
            if (mask_q[k] && (k > int'(ch))) begin
                next_ch = CH_W'(k);
                next_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            scan_pend   <= 1'b0;
            mask_q      <= '0;
            ch          <= '0;
            in_scan     <= 1'b0;
            smp_ok      <= 1'b0;
            b0          <= '0;
            b1          <= '0;
            wr_addr     <= '0;
            wr_dat      <= '0;
            i2c_cmd     <= '0;
            i2c_cmd_vld <= 1'b0;
            i2c_wr_data <= '0;
            smp_data    <= '0;
            smp_ch      <= '0;
            smp_vld     <= 1'b0;
            smp_bank    <= '0;
            scan_done   <= 1'b0;
            err         <= 1'b0;
        end else begin
            i2c_cmd_vld <= 1'b0;
            smp_vld     <= 1'b0;
            scan_done   <= 1'b0;
            err         <= 1'b0;

            if (!scan_en) begin
                cnt       <= '0;
                scan_pend <= 1'b0;
            end else if (cnt == CNT_W'(PERIOD_CYC-1)) begin
                cnt       <= '0;
                scan_pend <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A NACKed write byte always diverts to a STOP, whatever the sequence.
            if (i2c_done && i2c_ack_err &&
                (state inside {S_DEV, S_REG, S_RDEV, W_DEV, W_REG, W_DAT})) begin
                i2c_cmd     <= CMD_STOP;
                i2c_cmd_vld <= 1'b1;
                err         <= 1'b1;
                state       <= ABORT;
            end else begin
                case (state)
                    IDLE: begin
                        if (cfg_wr_req && ready) begin
                            wr_addr     <= cfg_reg_addr;
                            wr_dat      <= cfg_wr_data;
                            in_scan     <= 1'b0;
                            i2c_cmd     <= CMD_START | CMD_WRITE;
                            i2c_wr_data <= {DEV_ID, 1'b0};
                            i2c_cmd_vld <= 1'b1;
                            state       <= W_DEV;
                        end else if (scan_pend) begin
                            mask_q <= ch_mask;
                            if (!first_ok) begin
                                scan_pend <= 1'b0;
                            end else begin
                                ch          <= first_ch;
                                in_scan     <= 1'b1;
                                i2c_cmd     <= CMD_START | CMD_WRITE;
                                i2c_wr_data <= {DEV_ID, 1'b0};
                                i2c_cmd_vld <= 1'b1;
                                state       <= S_DEV;
                            end
                        end
                    end
                    S_DEV: if (i2c_done) begin
                        i2c_cmd     <= CMD_WRITE;
                        i2c_wr_data <= CH_REG_BASE + 8'(ch);
                        i2c_cmd_vld <= 1'b1;
                        state       <= S_REG;
                    end
                    S_REG: if (i2c_done) begin
                        i2c_cmd     <= CMD_START | CMD_WRITE;
                        i2c_wr_data <= {DEV_ID, 1'b1};
                        i2c_cmd_vld <= 1'b1;
                        state       <= S_RDEV;
                    end
                    S_RDEV: if (i2c_done) begin
                        i2c_cmd     <= CMD_READ | CMD_ACK;
                        i2c_cmd_vld <= 1'b1;
                        state       <= S_RB0;
                    end
                    S_RB0: if (i2c_done) begin
                        b0          <= i2c_rd_data;
                        i2c_cmd     <= CMD_READ | CMD_STOP;
                        i2c_cmd_vld <= 1'b1;
                        state       <= S_RB1;
                    end
                    S_RB1: if (i2c_done) begin
                        b1     <= i2c_rd_data;
                        smp_ok <= 1'b1;
                        state  <= S_NEXT;
                    end
                    S_NEXT: begin
                        // smp_ok is clear when arriving here from an aborted channel.
                        if (smp_ok) begin
                            smp_vld                              <= 1'b1;
                            smp_data                             <= sample;
                            smp_ch                               <= ch;
                            smp_bank[int'(ch)*DATA_W +: DATA_W] <= sample;
                        end
                        smp_ok <= 1'b0;
                        if (next_ok) begin
                            ch          <= next_ch;
                            i2c_cmd     <= CMD_START | CMD_WRITE;
                            i2c_wr_data <= {DEV_ID, 1'b0};
                            i2c_cmd_vld <= 1'b1;
                            state       <= S_DEV;
                        end else begin
                            scan_done <= 1'b1;
                            scan_pend <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    W_DEV: if (i2c_done) begin
                        i2c_cmd     <= CMD_WRITE;
                        i2c_wr_data <= wr_addr;
                        i2c_cmd_vld <= 1'b1;
                        state       <= W_REG;
                    end
                    W_REG: if (i2c_done) begin
                        i2c_cmd     <= CMD_WRITE | CMD_STOP;
                        i2c_wr_data <= wr_dat;
                        i2c_cmd_vld <= 1'b1;
                        state       <= W_DAT;
                    end
                    W_DAT: if (i2c_done) state <= IDLE;
                    ABORT: if (i2c_done) state <= in_scan ? S_NEXT : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
